exec_muldiv_ctrl: RTL and testbench
===================================

// Module: exec_muldiv_ctrl
// PURPOSE
//  Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU and MTHI/MTLO, sitting beside the execute-stage ALU.
//  Accepts one op from decode via valid/ready and runs a shift-add multiply or restoring divide, one bit per cycle.
//  Owns the HI/LO registers.
//  Raises stall_req so the pipeline interlocks MFHI/MFLO against an op that is still in flight.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width in bits; must be >= 4; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      decode presents an op
//  in_ready   out  1      sequencer accepts this cycle; = (state==IDLE) & ~flush
//  op         in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 accepted as NOP
//  rs         in   WIDTH  operand A / dividend / MTHI-MTLO source
//  rt         in   WIDTH  operand B / divisor
//  flush      in   1      abort in-flight op (branch mispredict/exception)
//  hilo_rd    in   1      decode holds MFHI/MFLO this cycle
//  stall_req  out  1      = hilo_rd & busy (combinational)
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse: HI/LO were just updated by a mul/div
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; done=0; busy=0; in_ready=1 on the cycle after reset is released.
//  Reset asserted mid-op: the op is abandoned and the reset values above apply.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - Accept: in_valid & in_ready at edge T. For mul/div, latch |rs|, |rt| (magnitudes when signed) and the sign flags.
//    Load cnt=WIDTH-1 and go to CALC.
//  - MTHI/MTLO complete at edge T: hi (or lo) <= rs. State stays IDLE; no busy, no done.
//  - Ops 6-7: consumed at edge T with no state change.
//  - CALC: one iteration per cycle, WIDTH cycles total; leave for FIX when cnt==0.
//    Multiply: 2*WIDTH-bit product accumulator.
//    Divide: restoring; remainder shifts left, divisor is subtracted, quotient bit = ~borrow.
//  - FIX (1 cycle): apply signs, then write hi/lo at the closing edge (T+WIDTH+1); go to DONE.
//    Signed MULT: negate the 2*WIDTH-bit product if sign(rs)^sign(rt).
//    Signed DIV: quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs); truncation toward zero.
//    Results: lo = product[W-1:0], hi = product[2W-1:W]; or lo = quotient, hi = remainder.
//  - DONE (1 cycle): done=1, then go to IDLE. A new op is accepted no earlier than edge T+WIDTH+3.
//  Divide by zero (rt==0, signed or unsigned): lo = all ones, hi = rs unmodified. Full latency is still taken.
//  Signed overflow, rs=MIN_INT and rt=-1: lo = MIN_INT, hi = 0 (natural WIDTH-bit wrap).
//  Flush:
//  - in CALC or FIX: go to IDLE at the next edge; hi/lo unchanged; no done.
//  - in IDLE: blocks acceptance that cycle (in_ready=0).
//  - in DONE: ignored, because hi/lo are already written.
//  in_valid while busy: not accepted; decode must hold op and operands stable until in_ready.
//  hilo_rd in the accept cycle (still IDLE): no stall; the reader sees the pre-op hi/lo, which is in-order correct.
//  All state updates are synchronous to clk; no combinational path from rs/rt to any output.
// TESTING (WIDTH=32)
//  1. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, accepted at edge T
//     -> hi=0xFFFFFFFE, lo=0x00000001 after edge T+33; done=1 in the following cycle; in_ready=1 one cycle later.
//  2. MULT rs=-3, rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU rs=100, rt=7 -> lo=14, hi=2.
//  3. DIV rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5.
//     DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0. Both after 34 edges.
//  4. Preload hi=0xAAAA via MTHI. Start MULT; assert flush on CALC cycle 10
//     -> busy=0 next cycle; hi stays 0xAAAA; no done; next op accepted immediately.
//  5. hilo_rd=1 throughout a DIVU -> stall_req=1 exactly for the 34 busy cycles.
//     in_valid=1 while busy -> in_ready=0 and no second op is started.
//  6. MTLO rs=0x1234 in IDLE -> lo=0x1234 after one edge with busy=0.
//     rst_n=0 mid-CALC -> hi=lo=0 and IDLE on the next edge.

Source files
------------

// File: rtl/exec_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exec_muldiv_ctrl
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO ownership
//               and MTHI/MTLO writes. Shift-add multiply and restoring divide,
//               one bit per cycle, with a stall request for MFHI/MFLO interlock.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    input  logic             hilo_rd,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    // Upper half: partial product (mul) or remainder (div).
    // Lower half: remaining multiplier bits (mul) or dividend/quotient (div).
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_a;
    logic               neg_b;

    logic               accept;
    logic               start;
    logic               signed_op;
    logic [WIDTH-1:0]   abs_rs;
    logic [WIDTH-1:0]   abs_rt;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_borrow;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign accept    = in_valid & in_ready;
    assign start     = accept & ~op[2];
    // MULT and DIV are the signed flavours (even opcodes below 4)
    assign signed_op = ~op[0];
    assign abs_rs    = (signed_op && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
    assign abs_rt    = (signed_op && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_next   = {mul_sum, acc[WIDTH-1:1]};
        div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff   = {1'b0, div_shift} - {2'b00, opb};
        div_borrow = div_diff[WIDTH+1];
        div_next   = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      acc[WIDTH-2:0], ~div_borrow};
    end

    // Sign fix-up and result selection, including the divide-by-zero case
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
        quo_fix  = (neg_a ^ neg_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        // A zero divisor never borrows, so the remainder ends up holding |rs|
        rem_fix  = neg_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (opb == {WIDTH{1'b0}}) begin
            res_hi = rem_fix;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush aborts only before results are committed
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)                state_nxt = S_CALC;
            S_CALC: if (flush)                state_nxt = S_IDLE;
                    else if (cnt == '0)       state_nxt = S_FIX;
            S_FIX:  state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM-derived outputs
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        in_ready  = (state == S_IDLE) & ~flush;
        stall_req = hilo_rd & busy;
    end

    // Datapath: operand capture, iteration, HI/LO writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                acc    <= {{WIDTH{1'b0}}, abs_rs};
                                opb    <= abs_rt;
                                cnt    <= CNT_W'(WIDTH - 1);
                                is_div <= op[1];
                                neg_a  <= signed_op & rs[WIDTH-1];
                                neg_b  <= signed_op & rt[WIDTH-1];
                            end
                            OP_MTHI: hi <= rs;
                            OP_MTLO: lo <= rs;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_muldiv_ctrl
// Description : Scoreboard bench for exec_muldiv_ctrl (WIDTH=32)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        hilo_rd;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          acc_cyc = 0;
    int          done_cnt = 0;
    logic [63:0] sb_q[$];

    exec_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .flush     (flush),
        .hilo_rd   (hilo_rd),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: returns {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = '0;
        case (o)
            3'd0: p = sa * sbv;
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Scoreboard: compare each done pulse against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [63:0] e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("result_hi", {32'b0, hi}, {32'b0, e[63:32]});
                check("result_lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        op = o; rs = a; rt = b; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (push && o < 3'd4) sb_q.push_back(model(o, a, b));
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 64'd0, 64'd1);
        lat = cyc - acc_cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int stalls;
        int rdy_bad;
        int dc;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; rs = '0; rt = '0; flush = 1'b0; hilo_rd = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_ready", {63'b0, in_ready}, 64'd1);

        // MULTU max*max, with latency and ready timing
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat);
        check("mul_latency", lat, 64'd33);
        check("ready_in_done", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        check("ready_after_done", {63'b0, in_ready}, 64'd1);

        // Signed/unsigned mixes and boundary divides
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);         wait_idle();
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_idle();
        do_op(3'd3, 32'd100, 32'd7, 1'b1);               wait_idle();
        do_op(3'd2, 32'd5, 32'd0, 1'b1);                 wait_idle();
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
        do_op(3'd3, 32'hDEAD_BEEF, 32'd0, 1'b1);         wait_idle();
        do_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b1);         wait_idle();
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_idle();

        // Flush mid-CALC leaves HI intact and emits no done
        do_op(3'd4, 32'h0000_AAAA, 32'd0, 1'b0);
        @(negedge clk);
        check("mthi_hi", {32'b0, hi}, 64'hAAAA);
        dc = done_cnt;
        do_op(3'd0, 32'd1234, 32'd5678, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_hi", {32'b0, hi}, 64'hAAAA);
        check("flush_ready", {63'b0, in_ready}, 64'd1);
        repeat (40) @(negedge clk);
        check("flush_no_done", done_cnt, dc);
        do_op(3'd1, 32'd3, 32'd9, 1'b1); wait_idle();

        // Stall window and no acceptance while busy
        @(negedge clk);
        op = 3'd3; rs = 32'd1000; rt = 32'd7; in_valid = 1'b1; hilo_rd = 1'b1;
        #1;
        check("stall_accept_cycle", {63'b0, stall_req}, 64'd0);
        @(posedge clk);
        sb_q.push_back(model(3'd3, 32'd1000, 32'd7));
        stalls = 0; rdy_bad = 0; dc = done_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (i < 30 && in_ready) rdy_bad++;
            if (i == 29) in_valid = 1'b0;
        end
        hilo_rd = 1'b0;
        check("stall_cycles", stalls, 64'd34);
        check("ready_while_busy", rdy_bad, 64'd0);
        check("single_done", done_cnt - dc, 64'd1);
        check("idle_after_div", {63'b0, busy}, 64'd0);

        // MTLO completes in IDLE without busy
        do_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
        check("mtlo_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        check("mtlo_lo", {32'b0, lo}, 64'h1234);

        // Ops 6/7 are consumed silently
        do_op(3'd6, 32'h5555_5555, 32'd1, 1'b0);
        @(negedge clk);
        check("nop_busy", {63'b0, busy}, 64'd0);
        check("nop_lo", {32'b0, lo}, 64'h1234);

        // Random operations
        for (int k = 0; k < 10; k++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (($urandom_range(0, 1) == 0) && ro[1]) rb = -rb;
            do_op(ro, ra, rb, 1'b1);
            wait_idle();
        end

        // Reset mid-CALC
        do_op(3'd0, 32'd77, 32'd88, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_hi", {32'b0, hi}, 64'd0);
        check("rstmid_lo", {32'b0, lo}, 64'd0);
        check("rstmid_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);

        check("sb_empty", sb_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
